// File: rtl/apb_pkg.sv
// apb_pkg: FSM state type and sizing helpers for the APB register-file slave.
package apb_pkg;
    typedef enum logic {IDLE, ACCESS} apb_state_t;
    function automatic int cnt_width(input int ws);
        return (ws > 0) ? $clog2(ws + 1) : 1;
    endfunction
    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB3 bus bundle; carries PSTRB only when APB_PSTRB_EN is defined.
interface apb_regfile_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PRWADDR;
    logic [DATA_W-1:0] PRWDATA;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    modport master (
        output PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA,
`ifdef APB_PSTRB_EN
        output PSTRB,
`endif
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA,
`ifdef APB_PSTRB_EN
        input  PSTRB,
`endif
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_mem.sv
// apb_regfile_mem: register storage with byte-enabled synchronous write, combinational read
// and synchronous reset of every word to RESET_VAL.
module apb_regfile_mem #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter int                IDX_W     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < DATA_W / 8; b++)
            if (we && wstrb[b]) mem_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: RESET_VAL};
        else mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB3 completer over a DEPTH-word register file with wait states and PSLVERR.
// Define APB_PSTRB_EN to add PSTRB byte strobes on writes; otherwise writes are full-word.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_regfile_slave_if.slave bus
);
    localparam int CNT_W = cnt_width(WAIT_STATES);
    localparam int LANES = lane_count(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rdata;
    logic [LANES-1:0]  strb_q, strb_d;
    logic              wr_q, wr_d;
    logic              setup, done, err;

    // done is the single PREADY cycle; a dropped PSEL in ACCESS aborts without completing
    always_comb begin
        setup   = state_q == IDLE && bus.PSEL && !bus.PENABLE;
        done    = state_q == ACCESS && bus.PSEL && cnt_q == '0;
        err     = addr_q >= ADDR_W'(DEPTH);
        state_d = setup ? ACCESS : (state_q == ACCESS && (!bus.PSEL || done)) ? IDLE : state_q;
        cnt_d   = setup ? CNT_W'(WAIT_STATES) : (state_q == ACCESS && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        addr_d  = setup ? bus.PRWADDR : addr_q;
        data_d  = setup ? bus.PRWDATA : data_q;
        wr_d    = setup ? bus.PWRITE : wr_q;
`ifdef APB_PSTRB_EN
        strb_d  = setup ? bus.PSTRB : strb_q;
`else
        strb_d  = '1;
`endif
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            strb_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            strb_q  <= strb_d;
        end
    end

    apb_regfile_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .RESET_VAL(RESET_VAL)
    ) u_mem (
        .clk(PCLK), .rst(PRESET), .we(done && wr_q && !err),
        .waddr(addr_q[IDX_W-1:0]), .wdata(data_q), .wstrb(strb_q),
        .raddr(addr_q[IDX_W-1:0]), .rdata(rdata)
    );

    assign bus.PREADY  = done;
    assign bus.PSLVERR = done && err;
    assign bus.PRDATA  = (done && !wr_q && !err) ? rdata : '0;
endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
Parametrised APB3 completer: a DEPTH-word register file behind the master's PRWADDR/PRWDATA bus.
- Adds programmable wait states, PSLVERR on out-of-range addresses, abort on PSEL drop, and back-to-back transfers.
- Sits beside the existing APB master and replaces the fixed single-register slave.

Parameters:
- DATA_W, 32, data bus width (multiple of 8).
- ADDR_W, 32, PRWADDR width; PRWADDR is a word index.
- DEPTH, 16, number of registers; valid indices 0..DEPTH-1.
- WAIT_STATES, 0, extra access cycles before PREADY (0..15).
- RESET_VAL, 0, reset value of every register.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PRWADDR  in  ADDR_W  word address from master.
- PRWDATA  in  DATA_W  write data from master.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1 at the edge):
  - state=IDLE, wait counter=0.
  - All registers = RESET_VAL.
  - PREADY=0, PSLVERR=0, PRDATA=0 from the next cycle.
  - Reset mid-transfer discards the transfer; no write occurs.
- FSM states:
  - IDLE: on PSEL=1, PENABLE=0, capture PRWADDR, PWRITE and PRWDATA. Load cnt=WAIT_STATES and go to ACCESS.
  - PENABLE=1 without a prior setup is ignored (stay IDLE).
  - ACCESS: if PSEL=0, abort to IDLE; no write, PREADY stays 0.
  - ACCESS with cnt>0: decrement cnt, PREADY=0.
  - ACCESS with cnt==0: PREADY=1 (combinational from state/cnt) for exactly one cycle, then go to IDLE.
- Latency: WAIT_STATES=0 gives the standard 2-cycle transfer (setup + access). Each wait state adds one access cycle.
- Write commit: the register updates on the edge that closes the PREADY=1 cycle, using the captured address and data.
- Read data: PRDATA = reg[captured addr] while PREADY=1 and the access is a read; otherwise 0.
- Error: a captured address >= DEPTH (full ADDR_W compare) completes normally with the same wait states, but:
  - PSLVERR=1 alongside PREADY.
  - No write occurs and PRDATA=0.
- Back-to-back: PSEL held high with PENABLE low in the cycle after completion is a new setup. Zero idle cycles are required between transfers.
- Stability: changes to PRWADDR/PRWDATA/PWRITE during ACCESS are ignored; the captured values are used.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined: adds port PSTRB (in, DATA_W/8 bits), captured at setup. A write updates only the bytes whose strobe bit is 1. PSTRB=0 completes with no change. Reads ignore PSTRB.
- Undefined: no PSTRB port; writes are full-word.

Decomposition:
- Package apb_pkg:
  - typedef enum apb_state_t {IDLE, ACCESS}.
  - Localparams for the wait-counter width, $clog2(WAIT_STATES+1) (min 1), and the byte-lane count.
- Sub-module apb_regfile_mem holds the register storage: synchronous write port with optional byte enables, combinational read port, synchronous reset to RESET_VAL. The top keeps the FSM, wait counter and error logic.

Test Plan:
- WAIT_STATES=0: write 0x00000309 to address 0, then read address 0 → PREADY high on the 2nd cycle of each transfer, PRDATA=0x00000309, PSLVERR=0.
- WAIT_STATES=2: write 0x534D4F4C to address 2 and read back → PREADY low for 2 access cycles and high on the 3rd, readback 0x534D4F4C.
- DEPTH=16: write 0xDEADBEEF to address 16, then read address 16 → PSLVERR=1 with PREADY; read returns 0; all registers unchanged.
- WAIT_STATES=3: deassert PSEL in the 2nd access cycle of a write of 0x4956414E to address 3 → no PREADY; reg[3] keeps its old value; next transfer succeeds.
- Back-to-back: writes to addresses 1 and 2 with PSEL held high, then PRESET pulsed during a third write → both writes land; after reset all registers = RESET_VAL, outputs 0.
- APB_PSTRB_EN: write 0xFFFFFFFF with PSTRB=4'b0101 over 0x00000000 → readback 0x00FF00FF.
